// File: rtl/ascon_serial_if_if.sv
// Bundles the serial GPIO pins and the parallel core-side bus of the ASCON
// serial front end. slave = device side, master = pads/core side.
interface ascon_serial_if_if #(
   parameter int K = 128,
   parameter int Y = 104,
   parameter int L = 40,
   parameter int N = 128,
   parameter int T = 128
);
   logic         key_si;
   logic         nonce_si;
   logic         ad_si;
   logic         data_si;
   logic         start_i;
   logic         decrypt_i;
   logic [K-1:0] key_o;
   logic [N-1:0] nonce_o;
   logic [L-1:0] ad_o;
   logic [Y-1:0] data_o;
   logic         decrypt_o;
   logic         core_start_o;
   logic         core_done_i;
   logic [Y-1:0] core_data_i;
   logic [T-1:0] core_tag_i;
   logic         data_so;
   logic         tag_so;
   logic         ready_o;

   modport slave (
      input  key_si, nonce_si, ad_si, data_si, start_i, decrypt_i,
             core_done_i, core_data_i, core_tag_i,
      output key_o, nonce_o, ad_o, data_o, decrypt_o, core_start_o,
             data_so, tag_so, ready_o
   );

   modport master (
      output key_si, nonce_si, ad_si, data_si, start_i, decrypt_i,
             core_done_i, core_data_i, core_tag_i,
      input  key_o, nonce_o, ad_o, data_o, decrypt_o, core_start_o,
             data_so, tag_so, ready_o
   );
endinterface

// File: rtl/ascon_serial_if.sv
// Serial front end of the ASCON core: shifts key/nonce/AD/data in MSB first,
// fires a single start pulse to the core, captures the result and shifts
// data and tag back out after a short hold, flagging ready throughout.
module ascon_serial_if #(
   parameter int K       = 128,
   parameter int Y       = 104,
   parameter int L       = 40,
   parameter int N       = 128,
   parameter int T       = 128,
   parameter int OUT_DLY = 4
) (
   input logic              clk,
   input logic              rst,
   ascon_serial_if_if.slave bus
);
   localparam int MAXKY   = (K > Y) ? K : Y;
   localparam int MAXLN   = (L > N) ? L : N;
   localparam int MAXW    = (MAXKY > MAXLN) ? MAXKY : MAXLN;
   localparam int MAXO    = (Y > T) ? Y : T;
   localparam int MAXWO   = (MAXW > MAXO) ? MAXW : MAXO;
   localparam int CNT_MAX = (MAXWO > OUT_DLY) ? MAXWO : OUT_DLY;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_LOAD, S_WAIT, S_RUN, S_HOLD, S_UNLOAD, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [K-1:0]  key_q, key_d;
   logic [N-1:0]  nonce_q, nonce_d;
   logic [L-1:0]  ad_q, ad_d;
   logic [Y-1:0]  data_q, data_d;
   logic          decrypt_q, decrypt_d;
   logic          core_start_q, core_start_d;
   logic [Y-1:0]  dsr_q, dsr_d;   // result data shift register
   logic [T-1:0]  tsr_q, tsr_d;   // tag shift register
   logic          ready_q, ready_d;

   // Next-state logic. Fields shift left so that after W samples the first
   // bit sits at the MSB; shorter fields simply stop shifting once full.
   // The output shift registers fill with zeros, which makes the tail of the
   // data stream and the DONE state read 0 without extra muxing.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      key_d        = key_q;
      nonce_d      = nonce_q;
      ad_d         = ad_q;
      data_d       = data_q;
      decrypt_d    = decrypt_q;
      core_start_d = 1'b0;
      dsr_d        = dsr_q;
      tsr_d        = tsr_q;
      ready_d      = ready_q;
      case (state_q)
         S_LOAD: begin
            if (cnt_q < CW'(K)) key_d   = {key_q[K-2:0],   bus.key_si};
            if (cnt_q < CW'(N)) nonce_d = {nonce_q[N-2:0], bus.nonce_si};
            if (cnt_q < CW'(L)) ad_d    = {ad_q[L-2:0],    bus.ad_si};
            if (cnt_q < CW'(Y)) data_d  = {data_q[Y-2:0],  bus.data_si};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(MAXW - 1)) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            if (bus.start_i) begin
               decrypt_d    = bus.decrypt_i;
               core_start_d = 1'b1;
               state_d      = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.core_done_i) begin
               dsr_d   = bus.core_data_i;
               tsr_d   = bus.core_tag_i;
               ready_d = 1'b1;
               state_d = S_HOLD;
               cnt_d   = '0;
            end
         end
         S_HOLD: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(OUT_DLY - 1)) begin
               state_d = S_UNLOAD;
               cnt_d   = '0;
            end
         end
         S_UNLOAD: begin
            dsr_d = {dsr_q[Y-2:0], 1'b0};
            tsr_d = {tsr_q[T-2:0], 1'b0};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(MAXO - 1)) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end
         end
         default: ;  // S_DONE: parked until reset
      endcase
   end

   // State and datapath registers, all cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_LOAD;
         cnt_q        <= '0;
         key_q        <= '0;
         nonce_q      <= '0;
         ad_q         <= '0;
         data_q       <= '0;
         decrypt_q    <= 1'b0;
         core_start_q <= 1'b0;
         dsr_q        <= '0;
         tsr_q        <= '0;
         ready_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         key_q        <= key_d;
         nonce_q      <= nonce_d;
         ad_q         <= ad_d;
         data_q       <= data_d;
         decrypt_q    <= decrypt_d;
         core_start_q <= core_start_d;
         dsr_q        <= dsr_d;
         tsr_q        <= tsr_d;
         ready_q      <= ready_d;
      end
   end

   assign bus.key_o        = key_q;
   assign bus.nonce_o      = nonce_q;
   assign bus.ad_o         = ad_q;
   assign bus.data_o       = data_q;
   assign bus.decrypt_o    = decrypt_q;
   assign bus.core_start_o = core_start_q;
   assign bus.data_so      = dsr_q[Y-1];
   assign bus.tag_so       = tsr_q[T-1];
   assign bus.ready_o      = ready_q;
endmodule

// File: tb/tb_ascon_serial_if.sv
// Bench for ascon_serial_if: known-answer encrypt/decrypt streams, ignored
// start/done conditions, reset during unload, held start, random traffic.
module tb_ascon_serial_if;
   localparam int K = 128, Y = 104, L = 40, N = 128, T = 128, OUT_DLY = 4;
   localparam int MAXO = 128;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   start_pulses = 0;

   logic [K-1:0] KEY   = 128'h6d4f8bbf60ec05a07b201d4e5b2119ac;
   logic [N-1:0] NONCE = 128'h05885e606e1271b8d47a74c7b297a318;
   logic [L-1:0] AD    = 40'h4153434f4e;
   logic [Y-1:0] PT    = 104'h6173636f6e2d756e6963617373;
   logic [Y-1:0] CT    = 104'h18490112f8d5867a830748390b;

   ascon_serial_if_if #(.K(K), .Y(Y), .L(L), .N(N), .T(T)) bus ();

   ascon_serial_if #(.K(K), .Y(Y), .L(L), .N(N), .T(T), .OUT_DLY(OUT_DLY)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // count cycles in which the core start strobe is high
   always @(negedge clk) if (bus.core_start_o === 1'b1) start_pulses++;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.key_si = 0; bus.nonce_si = 0; bus.ad_si = 0; bus.data_si = 0;
      bus.start_i = 0; bus.decrypt_i = 0; bus.core_done_i = 0;
      bus.core_data_i = '0; bus.core_tag_i = '0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   // Stream the four fields MSB first for 128 clocks; bits past a field's
   // width are random and must be ignored. Optionally hold start_i mid-load.
   task automatic load_fields(input logic [K-1:0] k, input logic [N-1:0] n,
                              input logic [L-1:0] a, input logic [Y-1:0] d,
                              input bit start_mid, input string name);
      int p0 = start_pulses;
      for (int i = 0; i < 128; i++) begin
         bus.key_si   = k[K-1-i];
         bus.nonce_si = n[N-1-i];
         bus.ad_si    = (i < L) ? a[L-1-i] : 1'($urandom_range(0, 1));
         bus.data_si  = (i < Y) ? d[Y-1-i] : 1'($urandom_range(0, 1));
         bus.start_i  = start_mid && i >= 50 && i < 120;
         tick();
      end
      bus.start_i = 0;
      n_checks++;
      if (bus.key_o !== k) begin n_fail++; $display("FAIL %s key_o got %h want %h", name, bus.key_o, k); end
      n_checks++;
      if (bus.nonce_o !== n) begin n_fail++; $display("FAIL %s nonce_o got %h want %h", name, bus.nonce_o, n); end
      n_checks++;
      if (bus.ad_o !== a) begin n_fail++; $display("FAIL %s ad_o got %h want %h", name, bus.ad_o, a); end
      n_checks++;
      if (bus.data_o !== d) begin n_fail++; $display("FAIL %s data_o got %h want %h", name, bus.data_o, d); end
      n_checks++;
      if (start_pulses != p0 || bus.ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL %s load_quiet pulses=%0d ready=%b want 0/0", name, start_pulses - p0, bus.ready_o);
      end
   endtask

   task automatic do_start(input bit dec, input string name);
      bus.start_i = 1; bus.decrypt_i = dec;
      tick();
      bus.start_i = 0; bus.decrypt_i = ~dec;
      n_checks++;
      if (bus.core_start_o !== 1'b1 || bus.decrypt_o !== dec) begin
         n_fail++;
         $display("FAIL %s start_pulse core_start=%b decrypt_o=%b want 1/%b", name, bus.core_start_o, bus.decrypt_o, dec);
      end
      tick();
      n_checks++;
      if (bus.core_start_o !== 1'b0 || bus.decrypt_o !== dec) begin
         n_fail++;
         $display("FAIL %s start_end core_start=%b decrypt_o=%b want 0/%b", name, bus.core_start_o, bus.decrypt_o, dec);
      end
   endtask

   // Core model: after a delay, present the result with a one-cycle done.
   task automatic respond(input logic [Y-1:0] d, input logic [T-1:0] t,
                          input int dly, input string name);
      int bad = 0;
      for (int i = 0; i < dly; i++) begin
         if (bus.ready_o !== 1'b0) bad++;
         tick();
      end
      bus.core_done_i = 1; bus.core_data_i = d; bus.core_tag_i = t;
      tick();
      bus.core_done_i = 0;
      bus.core_data_i = {$urandom, $urandom, $urandom, $urandom};
      bus.core_tag_i  = {$urandom, $urandom, $urandom, $urandom};
      n_checks++;
      if (bad != 0 || bus.ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s ready_rise ready=%b early_high=%0d want 1/0", name, bus.ready_o, bad);
      end
   endtask

   // Expected serial streams: OUT_DLY cycles of the MSB, then MAXO bit times
   // MSB first (data zero-padded past Y), then zeros in DONE.
   task automatic check_unload(input logic [Y-1:0] d, input logic [T-1:0] t,
                               input string name);
      bit exp_d[$], exp_t[$];
      int bad_d = 0, bad_t = 0, bad_r = 0, first_d = -1, first_t = -1;
      for (int k = 0; k < OUT_DLY; k++) begin exp_d.push_back(d[Y-1]); exp_t.push_back(t[T-1]); end
      for (int j = 0; j < MAXO; j++) begin
         exp_d.push_back(j < Y ? d[Y-1-j] : 1'b0);
         exp_t.push_back(j < T ? t[T-1-j] : 1'b0);
      end
      for (int k = 0; k < 6; k++) begin exp_d.push_back(1'b0); exp_t.push_back(1'b0); end
      for (int k = 0; k < exp_d.size(); k++) begin
         if (bus.data_so !== exp_d[k]) begin bad_d++; if (first_d < 0) first_d = k; end
         if (bus.tag_so  !== exp_t[k]) begin bad_t++; if (first_t < 0) first_t = k; end
         if (bus.ready_o !== 1'b1) bad_r++;
         tick();
      end
      n_checks++;
      if (bad_d != 0) begin n_fail++; $display("FAIL %s data_so %0d wrong bits, first at cycle %0d, want 0 wrong", name, bad_d, first_d); end
      n_checks++;
      if (bad_t != 0) begin n_fail++; $display("FAIL %s tag_so %0d wrong bits, first at cycle %0d, want 0 wrong", name, bad_t, first_t); end
      n_checks++;
      if (bad_r != 0) begin n_fail++; $display("FAIL %s ready_hold %0d low cycles, want 0", name, bad_r); end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      #1;
      repeat (2) tick();
      n_checks++;
      if ({bus.key_o, bus.nonce_o, bus.ad_o, bus.data_o, bus.decrypt_o,
           bus.core_start_o, bus.data_so, bus.tag_so, bus.ready_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_state outputs not all zero: ready=%b start=%b key=%h", bus.ready_o, bus.core_start_o, bus.key_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_encrypt();
      logic [T-1:0] t0 = {$urandom, $urandom, $urandom, $urandom};
      int p0;
      load_fields(KEY, NONCE, AD, PT, 1'b1, "enc");
      p0 = start_pulses;
      do_start(1'b0, "enc");
      respond(CT, t0, 3, "enc");
      check_unload(CT, t0, "enc");
      n_checks++;
      if (start_pulses - p0 != 1) begin n_fail++; $display("FAIL enc pulse_count got %0d want 1", start_pulses - p0); end
   endtask

   task automatic test_decrypt();
      logic [T-1:0] t1 = {$urandom, $urandom, $urandom, $urandom};
      apply_reset();
      load_fields(KEY, NONCE, AD, CT, 1'b0, "dec");
      // spurious done while waiting for start must be ignored
      bus.core_done_i = 1; bus.core_data_i = PT; bus.core_tag_i = t1;
      repeat (2) tick();
      bus.core_done_i = 0;
      n_checks++;
      if (bus.ready_o !== 1'b0 || bus.data_so !== 1'b0 || bus.tag_so !== 1'b0 || bus.core_start_o !== 1'b0) begin
         n_fail++;
         $display("FAIL dec spurious_done ready=%b data_so=%b tag_so=%b start=%b want 0", bus.ready_o, bus.data_so, bus.tag_so, bus.core_start_o);
      end
      do_start(1'b1, "dec");
      respond(PT, t1, 0, "dec");
      check_unload(PT, t1, "dec");
   endtask

   task automatic test_reset_mid_unload();
      logic [K-1:0] k = {$urandom, $urandom, $urandom, $urandom};
      logic [Y-1:0] d = {$urandom, $urandom, $urandom, $urandom};
      apply_reset();
      load_fields(KEY, NONCE, AD, CT, 1'b0, "rst_mid");
      do_start(1'b1, "rst_mid");
      respond({Y{1'b1}}, {T{1'b1}}, 1, "rst_mid");
      repeat (OUT_DLY + 20) tick();
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.key_o, bus.nonce_o, bus.ad_o, bus.data_o, bus.decrypt_o,
           bus.core_start_o, bus.data_so, bus.tag_so, bus.ready_o} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid outputs_zero ready=%b data_so=%b decrypt_o=%b want 0", bus.ready_o, bus.data_so, bus.decrypt_o);
      end
      tick();
      rst = 1'b0;
      // state must be back in LOAD: a fresh stream loads straight away
      load_fields(k, ~NONCE, ~AD, d, 1'b0, "rst_reload");
   endtask

   task automatic test_start_held();
      logic [T-1:0] t = {$urandom, $urandom, $urandom, $urandom};
      logic [Y-1:0] d = {$urandom, $urandom, $urandom, $urandom};
      int p0;
      apply_reset();
      load_fields(~KEY, NONCE, AD, PT, 1'b0, "held");
      p0 = start_pulses;
      bus.start_i = 1; bus.decrypt_i = 0;
      repeat (3) tick();
      respond(d, t, 2, "held");
      check_unload(d, t, "held");
      repeat (20) tick();
      bus.start_i = 0;
      n_checks++;
      if (start_pulses - p0 != 1) begin n_fail++; $display("FAIL held pulse_count got %0d want 1", start_pulses - p0); end
      n_checks++;
      if (bus.ready_o !== 1'b1 || bus.data_so !== 1'b0 || bus.tag_so !== 1'b0) begin
         n_fail++;
         $display("FAIL held done_state ready=%b data_so=%b tag_so=%b want 1/0/0", bus.ready_o, bus.data_so, bus.tag_so);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 3; it++) begin
         logic [K-1:0] k = {$urandom, $urandom, $urandom, $urandom};
         logic [N-1:0] n = {$urandom, $urandom, $urandom, $urandom};
         logic [L-1:0] a = {$urandom, $urandom};
         logic [Y-1:0] d = {$urandom, $urandom, $urandom, $urandom};
         logic [Y-1:0] r = {$urandom, $urandom, $urandom, $urandom};
         logic [T-1:0] t = {$urandom, $urandom, $urandom, $urandom};
         bit dec = 1'($urandom_range(0, 1));
         apply_reset();
         load_fields(k, n, a, d, 1'($urandom_range(0, 1)), "rand");
         repeat ($urandom_range(0, 4)) tick();
         do_start(dec, "rand");
         respond(r, t, $urandom_range(0, 6), "rand");
         check_unload(r, t, "rand");
      end
   endtask

   initial begin
      test_reset();
      test_encrypt();
      test_decrypt();
      test_reset_mid_unload();
      test_start_held();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
